// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption control sequencer: steps the permutation datapath through
// init, associated data, plaintext and finalization, one 64-bit block per handshake.
module ascon_ctrl_fsm #(
  parameter int unsigned NB_AD = 1,
  parameter int unsigned NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       enable_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_data_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_e_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_t;

  localparam logic [3:0] RC_LAST = 4'd11;
  localparam logic [3:0] AD_LAST = 4'(NB_AD - 1);
  localparam logic [3:0] PT_LAST = 4'(NB_PT - 1);

  state_t     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic [3:0] bc_q, bc_d;
  logic       cipher_valid_q;

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q        <= S_IDLE;
      rc_q           <= '0;
      bc_q           <= '0;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rc_q           <= rc_d;
      bc_q           <= bc_d;
      cipher_valid_q <= en_cipher_o;
    end
  end

  assign cipher_valid_o = cipher_valid_q;

  always_comb begin
    state_d         = state_q;
    rc_d            = rc_q;
    bc_d            = bc_q;
    data_ready_o    = 1'b0;
    enable_o        = 1'b0;
    select_o        = 1'b0;
    round_o         = '0;
    en_xor_key_b_o  = 1'b0;
    en_xor_data_b_o = 1'b0;
    en_xor_key_e_o  = 1'b0;
    en_xor_lsb_e_o  = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    busy_o          = (state_q != S_IDLE);
    tag_valid_o     = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          rc_d    = '0;
        end
      end
      S_INIT: begin
        enable_o = 1'b1;
        select_o = (rc_q != '0);
        round_o  = rc_q;
        if (rc_q == RC_LAST) begin
          en_xor_key_e_o = 1'b1;
          state_d        = S_WAIT_AD;
          bc_d           = '0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      S_WAIT_AD: begin
        // The block is absorbed in round 6 of the same cycle it is accepted.
        if (data_valid_i) begin
          data_ready_o    = 1'b1;
          enable_o        = 1'b1;
          select_o        = 1'b1;
          round_o         = 4'd6;
          en_xor_data_b_o = 1'b1;
          state_d         = S_AD;
          rc_d            = 4'd7;
        end
      end
      S_AD: begin
        enable_o = 1'b1;
        select_o = 1'b1;
        round_o  = rc_q;
        if (rc_q == RC_LAST) begin
          if (bc_q == AD_LAST) begin
            en_xor_lsb_e_o = 1'b1;
            state_d        = S_WAIT_PT;
            bc_d           = '0;
          end else begin
            bc_d    = bc_q + 4'd1;
            state_d = S_WAIT_AD;
          end
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      S_WAIT_PT: begin
        if (data_valid_i) begin
          data_ready_o    = 1'b1;
          enable_o        = 1'b1;
          select_o        = 1'b1;
          en_xor_data_b_o = 1'b1;
          en_cipher_o     = 1'b1;
          // Last plaintext block goes straight into the 12-round finalization.
          if (bc_q == PT_LAST) begin
            round_o        = '0;
            en_xor_key_b_o = 1'b1;
            state_d        = S_FINAL;
            rc_d           = 4'd1;
          end else begin
            round_o = 4'd6;
            state_d = S_PT;
            rc_d    = 4'd7;
          end
        end
      end
      S_PT: begin
        enable_o = 1'b1;
        select_o = 1'b1;
        round_o  = rc_q;
        if (rc_q == RC_LAST) begin
          bc_d    = bc_q + 4'd1;
          state_d = S_WAIT_PT;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      S_FINAL: begin
        enable_o = 1'b1;
        select_o = 1'b1;
        round_o  = rc_q;
        if (rc_q == RC_LAST) begin
          en_xor_key_e_o = 1'b1;
          en_tag_o       = 1'b1;
          state_d        = S_DONE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
